// File: rtl/stream_mux_pkg.sv
// -----------------------------------------------------------------------------
// stream_mux_pkg
//
// Shared definitions for the registered M-channel stream multiplexer:
//   - grant mode constants (external select vs. round-robin)
//   - output register state encoding
//   - sel_width(): width of a channel index for a given channel count
//
// No ports; imported by rr_arbiter_m and stream_mux_mxn.
// -----------------------------------------------------------------------------
package stream_mux_pkg;

    localparam int MUX_MODE_SEL = 0;
    localparam int MUX_MODE_RR  = 1;

    typedef enum logic {
        OUT_EMPTY = 1'b0,
        OUT_FULL  = 1'b1
    } out_state_t;

    // A single channel still needs a one-bit index so ports never collapse to zero width.
    function automatic int sel_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter_m.sv
// -----------------------------------------------------------------------------
// rr_arbiter_m
//
// Purely combinational round-robin arbiter. Starting one past the pointer and
// wrapping modulo M, it grants the first requesting channel.
//
// Parameters:
//   M   number of requesters
//   SW  index width
// Ports:
//   req        in   M   request vector, bit i = channel i
//   ptr        in   SW  last granted channel; search begins at ptr+1
//   grant      out  M   one-hot grant, zero when nothing requests
//   grant_idx  out  SW  index of the granted channel (0 when none)
//   grant_vld  out  1   some channel was granted
// -----------------------------------------------------------------------------
module rr_arbiter_m
    import stream_mux_pkg::*;
#(
    parameter int M  = 4,
    parameter int SW = sel_width(M)
) (
    input  logic [M-1:0]  req,
    input  logic [SW-1:0] ptr,
    output logic [M-1:0]  grant,
    output logic [SW-1:0] grant_idx,
    output logic          grant_vld
);

    // Walk the M candidates in priority order; the first hit latches grant_vld
    // so later candidates cannot override it.
    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        grant_vld = 1'b0;
        idx       = 0;
        for (int k = 1; k <= M; k++) begin
            idx = (int'(ptr) + k) % M;
            if (!grant_vld && req[idx]) begin
                grant_vld  = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = SW'(idx);
            end
        end
    end

endmodule

// File: rtl/stream_mux_mxn.sv
// -----------------------------------------------------------------------------
// stream_mux_mxn
//
// Registered, valid/ready M-channel stream multiplexer. One beat per cycle is
// moved from the granted input channel into a single-entry output register.
// The grant is either the external 'sel' input (MODE=0) or a round-robin
// arbiter (MODE=1).
//
// Optional feature (macro MUX_BURST_LOCK_EN): adds an in_last port; in
// round-robin mode the grant is held on a channel until it transfers a beat
// with in_last set, so bursts are never interleaved.
//
// Parameters:
//   M     number of input channels (1..16)
//   N     data width per channel
//   MODE  MUX_MODE_SEL (0) or MUX_MODE_RR (1)
//   SW    channel index width, derived from M
// Ports:
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous active-high reset
//   sel        in   SW   channel select (MODE=0 only)
//   in_valid   in   M    per-channel valid
//   in_ready   out  M    per-channel ready, one-hot or zero
//   in_data    in   M*N  packed channels, ch i at [i*N +: N]
//   in_last    in   M    end-of-burst marker (MUX_BURST_LOCK_EN only)
//   out_valid  out  1    output register holds a beat
//   out_ready  in   1    consumer accepts the beat
//   out_data   out  N    registered data
//   out_ch     out  SW   channel that sourced out_data
// -----------------------------------------------------------------------------
module stream_mux_mxn
    import stream_mux_pkg::*;
#(
    parameter int M    = 4,
    parameter int N    = 8,
    parameter int MODE = MUX_MODE_RR,
    parameter int SW   = sel_width(M)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [SW-1:0]  sel,
    input  logic [M-1:0]   in_valid,
    output logic [M-1:0]   in_ready,
    input  logic [M*N-1:0] in_data,
`ifdef MUX_BURST_LOCK_EN
    input  logic [M-1:0]   in_last,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   out_data,
    output logic [SW-1:0]  out_ch
);

    out_state_t    state;
    out_state_t    state_nxt;
    logic          load_en;
    logic          in_xfer;
    logic          grant_vld;
    logic [M-1:0]  grant_oh;
    logic [SW-1:0] g;
    logic [SW-1:0] rr_ptr;
`ifdef MUX_BURST_LOCK_EN
    logic          lock;
`endif

    assign out_valid = (state == OUT_FULL);

    generate
        if (MODE == MUX_MODE_SEL) begin : g_sel_mode
            // External select: a select beyond the channel count grants nothing,
            // which also keeps the index below from reaching a missing channel.
            always_comb begin
                g         = sel;
                grant_oh  = '0;
                grant_vld = 1'b0;
                if (int'(sel) < M) begin
                    grant_vld     = in_valid[sel];
                    grant_oh[sel] = in_valid[sel];
                end
            end

            logic unused_sel_mode;
`ifdef MUX_BURST_LOCK_EN
            assign unused_sel_mode = ^{rr_ptr, lock, in_last};
`else
            assign unused_sel_mode = ^rr_ptr;
`endif
        end else begin : g_rr_mode
            logic [M-1:0]  arb_grant;
            logic [SW-1:0] arb_idx;
            logic          arb_vld;

            rr_arbiter_m #(
                .M  (M),
                .SW (SW)
            ) u_arb (
                .req       (in_valid),
                .ptr       (rr_ptr),
                .grant     (arb_grant),
                .grant_idx (arb_idx),
                .grant_vld (arb_vld)
            );

            // While a burst is open the grant is pinned to the channel that
            // opened it (always rr_ptr, since the pointer follows every
            // transfer); other channels wait even if that channel goes idle.
            always_comb begin
                g         = arb_idx;
                grant_oh  = arb_grant;
                grant_vld = arb_vld;
`ifdef MUX_BURST_LOCK_EN
                if (lock) begin
                    g                = rr_ptr;
                    grant_oh         = '0;
                    grant_oh[rr_ptr] = in_valid[rr_ptr];
                    grant_vld        = in_valid[rr_ptr];
                end
`endif
            end

            logic unused_rr_mode;
            assign unused_rr_mode = ^sel;
        end
    endgenerate

    // The output register can take a new beat when it is empty or when its
    // current beat leaves this same cycle, so a full pipe sustains one beat
    // per cycle.
    always_comb begin
        state_nxt = state;
        load_en   = (state == OUT_EMPTY) || out_ready;
        in_xfer   = load_en && grant_vld;
        if (in_xfer) begin
            state_nxt = OUT_FULL;
        end else if (out_ready) begin
            state_nxt = OUT_EMPTY;
        end
    end

    assign in_ready = load_en ? grant_oh : '0;

    // Output register, round-robin pointer and burst lock. The pointer resets
    // to M-1 so the very first search begins at channel 0, and it only moves
    // on an actual input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= OUT_EMPTY;
            out_data <= '0;
            out_ch   <= '0;
            rr_ptr   <= SW'(M - 1);
`ifdef MUX_BURST_LOCK_EN
            lock     <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (in_xfer) begin
                out_data <= in_data[int'(g)*N +: N];
                out_ch   <= g;
                rr_ptr   <= g;
`ifdef MUX_BURST_LOCK_EN
                if (MODE == MUX_MODE_RR) begin
                    lock <= !in_last[g];
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_stream_mux_mxn.sv
// -----------------------------------------------------------------------------
// tb_stream_mux_mxn
//
// Three instances share one clock and reset:
//   dut 0: MODE=0, M=8, N=5   (external select)
//   dut 1: MODE=1, M=4, N=8   (round-robin, burst lock when MUX_BURST_LOCK_EN)
//   dut 2: MODE=0, M=6, N=8   (select range wider than channel count)
// A behavioural reference model tracks every instance every cycle; directed
// tables and sequences add fixed expected values on top.
// -----------------------------------------------------------------------------
module tb_stream_mux_mxn;

`ifdef MUX_BURST_LOCK_EN
    localparam bit LOCK_EN = 1'b1;
`else
    localparam bit LOCK_EN = 1'b0;
`endif

    int dm    [3] = '{8, 4, 6};
    int dn    [3] = '{5, 8, 8};
    int dmode [3] = '{0, 1, 0};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [15:0]  s_v    [3];
    logic [127:0] s_d    [3];
    int           s_sel  [3];
    logic         s_r    [3];
    logic [15:0]  s_last [3];

    logic [7:0] rdy0;  logic ov0;  logic [4:0] od0;  logic [2:0] oc0;
    logic [3:0] rdy1;  logic ov1;  logic [7:0] od1;  logic [1:0] oc1;
    logic [5:0] rdy2;  logic ov2;  logic [7:0] od2;  logic [2:0] oc2;

    stream_mux_mxn #(.M(8), .N(5), .MODE(0)) dut0 (
        .clk(clk), .rst(rst), .sel(3'(s_sel[0])),
        .in_valid(s_v[0][7:0]), .in_ready(rdy0), .in_data(s_d[0][39:0]),
`ifdef MUX_BURST_LOCK_EN
        .in_last(s_last[0][7:0]),
`endif
        .out_valid(ov0), .out_ready(s_r[0]), .out_data(od0), .out_ch(oc0)
    );

    stream_mux_mxn #(.M(4), .N(8), .MODE(1)) dut1 (
        .clk(clk), .rst(rst), .sel(2'(s_sel[1])),
        .in_valid(s_v[1][3:0]), .in_ready(rdy1), .in_data(s_d[1][31:0]),
`ifdef MUX_BURST_LOCK_EN
        .in_last(s_last[1][3:0]),
`endif
        .out_valid(ov1), .out_ready(s_r[1]), .out_data(od1), .out_ch(oc1)
    );

    stream_mux_mxn #(.M(6), .N(8), .MODE(0)) dut2 (
        .clk(clk), .rst(rst), .sel(3'(s_sel[2])),
        .in_valid(s_v[2][5:0]), .in_ready(rdy2), .in_data(s_d[2][47:0]),
`ifdef MUX_BURST_LOCK_EN
        .in_last(s_last[2][5:0]),
`endif
        .out_valid(ov2), .out_ready(s_r[2]), .out_data(od2), .out_ch(oc2)
    );

    // Uniform view of the three instances' outputs.
    logic [15:0] g_rdy [3];
    logic        g_ov  [3];
    int          g_od  [3];
    int          g_oc  [3];

    always_comb begin
        g_rdy[0] = 16'(rdy0); g_ov[0] = ov0; g_od[0] = int'(od0); g_oc[0] = int'(oc0);
        g_rdy[1] = 16'(rdy1); g_ov[1] = ov1; g_od[1] = int'(od1); g_oc[1] = int'(oc1);
        g_rdy[2] = 16'(rdy2); g_ov[2] = ov2; g_od[2] = int'(od2); g_oc[2] = int'(oc2);
    end

    int checks;
    int errors;

    // Reference model state: what the output register should hold, the channel
    // served most recently, and whether a burst is currently open.
    int m_valid [3];
    int m_data  [3];
    int m_ch    [3];
    int m_last  [3];
    int m_lock  [3];

    typedef struct {
        int          dut;
        logic [15:0] valid;
        int          sel;
        logic        ready;
        logic        exp_valid;
        int          exp_ch;
        int          exp_data;
    } vec_t;

    vec_t vecs[$];
    int   seq_all   [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    int   seq_drop  [6] = '{0, 2, 3, 0, 2, 3};
`ifdef MUX_BURST_LOCK_EN
    int   seq_burst [5] = '{2, 2, 2, 3, 0};
`else
    int   seq_burst [5] = '{2, 3, 0, 2, 3};
`endif

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input int k, input logic [15:0] v, input int sel, input logic r);
        s_v[k]   = v;
        s_sel[k] = sel;
        s_r[k]   = r;
    endtask

    function automatic vec_t make_vec(input int dut, input logic [15:0] valid, input int sel,
                                      input logic ready, input logic ev, input int ec, input int ed);
        vec_t v;
        v.dut = dut; v.valid = valid; v.sel = sel; v.ready = ready;
        v.exp_valid = ev; v.exp_ch = ec; v.exp_data = ed;
        return v;
    endfunction

    // Which channel the rules say wins this cycle, or -1 for none.
    function automatic int model_grant(input int k);
        int m;
        m = dm[k];
        if (dmode[k] == 0) begin
            if (s_sel[k] < m && s_v[k][s_sel[k]]) return s_sel[k];
            return -1;
        end
        if (m_lock[k] != 0) return s_v[k][m_last[k]] ? m_last[k] : -1;
        for (int j = 1; j <= m; j++) begin
            if (s_v[k][(m_last[k] + j) % m]) return (m_last[k] + j) % m;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 3; k++) begin
            m_valid[k] = 0; m_data[k] = 0; m_ch[k] = 0;
            m_last[k] = dm[k] - 1; m_lock[k] = 0;
        end
    endfunction

    // One clock: check combinational ready against the model, clock, advance
    // the model, check the registered outputs of every instance.
    task automatic cycle();
        int g  [3];
        bit ld [3];
        #1;
        for (int k = 0; k < 3; k++) begin
            ld[k] = (m_valid[k] == 0) || s_r[k];
            g[k]  = model_grant(k);
            if (!rst) begin
                checkOutput($sformatf("in_ready dut%0d", k), 128'(g_rdy[k]),
                            (ld[k] && g[k] >= 0) ? (128'(1) << g[k]) : 128'(0));
            end
        end
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else begin
            for (int k = 0; k < 3; k++) begin
                if (ld[k] && g[k] >= 0) begin
                    m_valid[k] = 1;
                    m_data[k]  = int'((s_d[k] >> (g[k] * dn[k])) & ((128'(1) << dn[k]) - 128'(1)));
                    m_ch[k]    = g[k];
                    m_last[k]  = g[k];
                    m_lock[k]  = (dmode[k] == 1 && LOCK_EN && !s_last[k][g[k]]) ? 1 : 0;
                end else if (s_r[k]) begin
                    m_valid[k] = 0;
                end
            end
        end
        for (int k = 0; k < 3; k++) begin
            checkOutput($sformatf("out_valid dut%0d", k), 128'(g_ov[k]), 128'(m_valid[k]));
            checkOutput($sformatf("out_data dut%0d", k),  128'(g_od[k]), 128'(m_data[k]));
            checkOutput($sformatf("out_ch dut%0d", k),    128'(g_oc[k]), 128'(m_ch[k]));
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        for (int k = 0; k < 3; k++) begin
            s_v[k] = '0; s_d[k] = '0; s_sel[k] = 0; s_r[k] = 1'b1; s_last[k] = '1;
        end
        model_reset();

        cycle();
        cycle();
        rst = 1'b0;
        checkOutput("reset out_valid", 128'(ov1), 128'(0));
        checkOutput("reset out_ch", 128'(oc1), 128'(0));

        for (int i = 0; i < 8; i++) s_d[0] |= 128'(i + 1) << (i * 5);
        for (int i = 0; i < 6; i++) s_d[2] |= 128'(8'h10 + i) << (i * 8);
        for (int i = 0; i < 4; i++) s_d[1] |= 128'(8'hA0 + i) << (i * 8);

        // Select mode stepping through all channels, then select boundaries.
        for (int i = 0; i < 8; i++) vecs.push_back(make_vec(0, 16'hFF, i, 1'b1, 1'b1, i, i + 1));
        vecs.push_back(make_vec(2, 16'h3F, 2, 1'b1, 1'b1, 2, 'h12));
        vecs.push_back(make_vec(2, 16'h3F, 7, 1'b1, 1'b0, 0, 0));
        vecs.push_back(make_vec(2, 16'h3F, 5, 1'b1, 1'b1, 5, 'h15));
        vecs.push_back(make_vec(2, 16'h00, 5, 1'b1, 1'b0, 0, 0));

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].dut, vecs[i].valid, vecs[i].sel, vecs[i].ready);
            cycle();
            checkOutput($sformatf("vec%0d out_valid", i), 128'(g_ov[vecs[i].dut]), 128'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                checkOutput($sformatf("vec%0d out_ch", i),   128'(g_oc[vecs[i].dut]), 128'(vecs[i].exp_ch));
                checkOutput($sformatf("vec%0d out_data", i), 128'(g_od[vecs[i].dut]), 128'(vecs[i].exp_data));
            end
        end
        applyStimulus(0, 16'h0, 0, 1'b1);

        // Round-robin with all channels valid, then with channel 1 idle.
        applyStimulus(1, 16'hF, 0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            cycle();
            checkOutput("rr all out_ch", 128'(oc1), 128'(seq_all[i]));
            checkOutput("rr all out_data", 128'(od1), 128'(8'hA0 + seq_all[i]));
        end
        applyStimulus(1, 16'hD, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            cycle();
            checkOutput("rr drop out_ch", 128'(oc1), 128'(seq_drop[i]));
        end

        // Backpressure: hold for three cycles, then release and reload at once.
        applyStimulus(1, 16'hF, 0, 1'b1);
        cycle();
        checkOutput("pre-stall out_ch", 128'(oc1), 128'(0));
        applyStimulus(1, 16'hF, 0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            checkOutput("stall out_valid", 128'(ov1), 128'(1));
            checkOutput("stall out_ch", 128'(oc1), 128'(0));
            checkOutput("stall out_data", 128'(od1), 128'(8'hA0));
            checkOutput("stall in_ready", 128'(rdy1), 128'(0));
        end
        applyStimulus(1, 16'hF, 0, 1'b1);
        #1;
        checkOutput("release in_ready", 128'(rdy1), 128'(4'b0010));
        cycle();
        checkOutput("release out_ch", 128'(oc1), 128'(1));

        // Reset while a beat is held.
        applyStimulus(1, 16'hF, 0, 1'b0);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        checkOutput("mid reset out_valid", 128'(ov1), 128'(0));
        checkOutput("mid reset out_data", 128'(od1), 128'(0));
        checkOutput("mid reset out_ch", 128'(oc1), 128'(0));
        applyStimulus(1, 16'hF, 0, 1'b1);
        cycle();
        checkOutput("first grant after reset", 128'(oc1), 128'(0));

        // Burst from channel 2 while channels 0 and 3 compete.
        applyStimulus(1, 16'h2, 0, 1'b1);
        cycle();
        s_last[1] = 16'hFFFB;
        applyStimulus(1, 16'hD, 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            if (i == 2) s_last[1] = '1;
            cycle();
            checkOutput("burst out_ch", 128'(oc1), 128'(seq_burst[i]));
        end

        // Randomized traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 3; k++) begin
                s_v[k]    = 16'($urandom) & 16'((1 << dm[k]) - 1);
                s_d[k]    = {$urandom, $urandom, $urandom, $urandom};
                s_sel[k]  = (dm[k] == 4) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 7));
                s_r[k]    = ($urandom % 4) != 0;
                s_last[k] = 16'($urandom);
            end
            rst = ($urandom % 64) == 0;
            cycle();
        end
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_mux_mxn.md
Name: stream_mux_mxn

Overview:
- Registered, handshaked successor to the combinational M-channel N-bit multiplexer.
- Selects one of M valid/ready input streams and forwards one beat per cycle into a single-entry output register.
- Grant is either externally selected (MODE=0, same semantics as the combinational mux) or round-robin arbitrated (MODE=1).
- Used to merge CPU-side producers (e.g. pixel/command sources) onto one consumer such as the HDMI framebuffer writer.

Parameters:
- M, 4: number of input channels; legal range 1..16.
- N, 8: data width per channel, in bits; minimum 1.
- MODE, 1: 0 = external select, 1 = round-robin arbitration.
- SW, (M>1 ? $clog2(M) : 1): select/channel-id width; derived, must not be overridden.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- rst  in  1  synchronous reset, active-high.
- sel  in  SW  channel select; used only when MODE=0.
- in_valid  in  M  per-channel valid; bit i belongs to channel i.
- in_ready  out  M  per-channel ready; one-hot or zero.
- in_data  in  M*N  packed channels {ch[M-1],...,ch[0]}; ch i occupies bits [i*N +: N].
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  consumer accepts the beat.
- out_data  out  N  registered data.
- out_ch  out  SW  index of the channel that sourced out_data.
- in_last  in  M  end-of-burst marker; port exists only when MUX_BURST_LOCK_EN is defined.

Behaviour:
- Reset: out_valid=0, out_data=0, out_ch=0, rr_ptr=M-1 so the first search starts at ch0, lock=0. Reset overrides every other input, including mid-transfer. A held beat is discarded.
- Output register (two states, EMPTY and FULL):
  - load_en = !out_valid || out_ready.
  - Output transfer: out_valid && out_ready.
  - Input transfer on channel g: in_valid[g] && in_ready[g].
- in_ready[i] = load_en && grant_vld && (g==i). It is combinational from in_valid, sel, out_ready and state, and never depends on in_data.
- Latency: a beat accepted in cycle t appears on out_data in cycle t+1.
- Throughput: 1 beat/cycle when out_ready is held high. A simultaneous drain and load in the same cycle is legal: the old beat leaves and the new beat is registered.
- When out_valid=1 and out_ready=0, out_data and out_ch stay stable and every in_ready is 0.
- MODE=0 grant:
  - g = sel; grant_vld = in_valid[sel].
  - sel >= M gives grant_vld=0, so nothing is accepted.
  - sel may change every cycle; only the value in the accepting cycle matters.
- MODE=1 grant:
  - Search starts at (rr_ptr+1) mod M, wraps modulo M, and picks the first channel with in_valid=1.
  - rr_ptr updates to g only on an input transfer. It does not move when no channel is valid or when the output is stalled.
  - Fairness: with all M channels continuously valid, each channel is served exactly once per M transfers.
- M=1: g=0 always; out_ch=0.
- Data handling: out_data is a bit-exact copy of ch[g]; no width conversion or arithmetic.

Optional Feature:
- Macro: MUX_BURST_LOCK_EN.
- Defined:
  - Adds the in_last port and a lock flag.
  - In MODE=1, after a transfer from g with in_last[g]=0, lock=1 and the grant stays on g even if g deasserts valid. Other channels wait.
  - lock clears on a transfer with in_last[g]=1; only then does the round-robin pointer advance past g.
  - In MODE=0, in_last is ignored.
  - rst clears lock.
- Undefined: no in_last port; arbitration is per beat.

Decomposition:
- Package stream_mux_pkg holds:
  - mode constants MUX_MODE_SEL=0 and MUX_MODE_RR=1;
  - the function sel_width(M).
- One natural sub-module, rr_arbiter_m: purely combinational. It takes a request vector and a pointer and returns a one-hot grant plus the grant index.
- The output register, rr_ptr and lock stay in stream_mux_mxn.

Test Plan:
1. MODE=0, M=8, N=5, ch i = i+1, all valid, out_ready=1, sel stepping 0..7 one per cycle:
   - out_data is 1..8 one cycle later;
   - out_ch equals the previous cycle's sel.
2. MODE=1, M=4, N=8, all valid, out_ready=1:
   - out_ch sequence is 0,1,2,3,0,… with one beat per cycle.
   - Then drop ch1 valid: sequence becomes 0,2,3,0,2,3.
3. Backpressure: out_ready=0 for 3 cycles with out_valid=1:
   - out_data and out_ch are held;
   - every in_ready is 0;
   - rr_ptr is unchanged.
   - On out_ready=1 the next beat loads in the same cycle.
4. Boundaries: MODE=0 with sel=7 on M=6 gives no acceptance and out_valid goes to 0. With no channel valid, out_valid goes to 0 after draining.
5. Assert rst for 1 cycle while out_valid=1 with a beat held:
   - next cycle out_valid=0, out_data=0, out_ch=0;
   - first round-robin grant after reset is ch0.
6. With MUX_BURST_LOCK_EN, MODE=1, M=4:
   - ch2 sends 3 beats with in_last=0,0,1 while ch0 and ch3 are valid: out_ch sequence is 2,2,2,3,0.
   - Repeat without the macro: sequence is 2,3,0,….
